// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_fetch_unit                                                 |
// | Brief    : Fetch PC generator with in-order req/gnt/rvalid bus requests, |
// |            a DEPTH-entry prefetch queue and redirect with squashing of   |
// |            in-flight responses.                                          |
// | Options  : FETCH_PERF_CNT_EN adds a saturating fetch-stall counter port. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pc_fetch_unit #(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int unsigned       DEPTH      = 4,
   parameter int unsigned       INC        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jtag_reset_flag_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_i,
   output logic              req_o,
   output logic [ADDR_W-1:0] req_addr_o,
   input  logic              gnt_i,
   input  logic              rvalid_i,
   input  logic [ADDR_W-1:0] rdata_i,
   output logic              inst_valid_o,
   output logic [ADDR_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   input  logic              inst_ready_i
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_stall_cnt_o
`endif
);

   localparam int unsigned       IDX_W     = $clog2(DEPTH);
   localparam int unsigned       PTR_W     = IDX_W + 1;
   localparam logic [PTR_W:0]    C_DEPTH   = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0]  C_PTR_ONE = PTR_W'(1);
   localparam logic [ADDR_W-1:0] C_INC     = ADDR_W'(INC);

   // Registered state
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [ADDR_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] data_d [DEPTH];
   logic [DEPTH-1:0]  dvalid_q, dvalid_d;
   logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d;
   logic [PTR_W-1:0]  data_ptr_q, data_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  discard_q, discard_d;
   logic              started_q, started_d;

   // Combinational helpers
   logic              w_redirect;
   logic [ADDR_W-1:0] w_target;
   logic [PTR_W-1:0]  w_allocated;
   logic [PTR_W:0]    w_occupancy;
   logic              w_credit;
   logic [IDX_W-1:0]  w_alloc_idx;
   logic [IDX_W-1:0]  w_data_idx;
   logic [IDX_W-1:0]  w_rd_idx;
   logic              w_discard_nz;
   logic              w_grant;
   logic              w_resp_drop;
   logic              w_resp_write;
   logic              w_pop;

   // The soft reset is simply a redirect to RESET_ADDR and wins over a jump.
   assign w_redirect   = jtag_reset_flag_i | jump_flag_i;
   assign w_target     = jtag_reset_flag_i ? RESET_ADDR : jump_addr_i;

   // Credit counts both live entries and responses still owed to squashed requests.
   assign w_allocated  = alloc_ptr_q - rd_ptr_q;
   assign w_occupancy  = {1'b0, w_allocated} + {1'b0, discard_q};
   assign w_credit     = (w_occupancy < C_DEPTH);

   assign w_alloc_idx  = alloc_ptr_q[IDX_W-1:0];
   assign w_data_idx   = data_ptr_q[IDX_W-1:0];
   assign w_rd_idx     = rd_ptr_q[IDX_W-1:0];
   assign w_discard_nz = |discard_q;

   assign req_o        = started_q & w_credit & ~hold_i & ~w_redirect;
   assign req_addr_o   = pc_q;

   assign inst_valid_o = (data_ptr_q != rd_ptr_q) & dvalid_q[w_rd_idx];
   assign inst_o       = data_q[w_rd_idx];
   assign inst_addr_o  = addr_q[w_rd_idx];

   assign w_grant      = req_o & gnt_i;
   assign w_resp_drop  = rvalid_i & w_discard_nz;
   assign w_resp_write = rvalid_i & ~w_discard_nz;
   assign w_pop        = inst_valid_o & inst_ready_i;

   // Next-state computation for PC, queue contents, pointers and discard count.
   always_comb begin
      pc_d        = pc_q;
      addr_d      = addr_q;
      data_d      = data_q;
      dvalid_d    = dvalid_q;
      alloc_ptr_d = alloc_ptr_q;
      data_ptr_d  = data_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      discard_d   = discard_q;
      started_d   = 1'b1;

      if (w_redirect) begin
         pc_d        = w_target;
         alloc_ptr_d = '0;
         data_ptr_d  = '0;
         rd_ptr_d    = '0;
         // Every granted request without data yet will still return a response
         // that must be dropped. A response arriving right now is either one
         // already counted in discard_q (drop) or the oldest of the
         // alloc-data outstanding ones (already returned), so one is
         // subtracted in both cases.
         discard_d   = discard_q + (alloc_ptr_q - data_ptr_q)
                       - (rvalid_i ? C_PTR_ONE : '0);
      end else begin
         if (w_grant) begin
            addr_d[w_alloc_idx]   = pc_q;
            dvalid_d[w_alloc_idx] = 1'b0;
            alloc_ptr_d           = alloc_ptr_q + C_PTR_ONE;
            pc_d                  = pc_q + C_INC;
         end
         if (w_resp_drop) begin
            discard_d = discard_q - C_PTR_ONE;
         end
         if (w_resp_write) begin
            data_d[w_data_idx]   = rdata_i;
            dvalid_d[w_data_idx] = 1'b1;
            data_ptr_d           = data_ptr_q + C_PTR_ONE;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_ADDR;
         dvalid_q    <= '0;
         alloc_ptr_q <= '0;
         data_ptr_q  <= '0;
         rd_ptr_q    <= '0;
         discard_q   <= '0;
         started_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         pc_q        <= pc_d;
         dvalid_q    <= dvalid_d;
         alloc_ptr_q <= alloc_ptr_d;
         data_ptr_q  <= data_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         discard_q   <= discard_d;
         started_q   <= started_d;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count cycles where decode is ready but has nothing to take; saturating.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (inst_ready_i && !inst_valid_o && started_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter register; only the hard reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pc_fetch_unit                                              |
// | Brief    : Self-checking bench for pc_fetch_unit: directed scenarios and |
// |            randomized traffic against a queue-based reference model.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pc_fetch_unit;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned INC   = 4;
   localparam logic [31:0] RST_A = 32'h0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          have;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        jtag_reset_flag_i = 1'b0;
   logic        jump_flag_i = 1'b0;
   logic [31:0] jump_addr_i = '0;
   logic        hold_i = 1'b0;
   logic        gnt_i = 1'b0;
   logic        rvalid_i = 1'b0;
   logic [31:0] rdata_i = '0;
   logic        inst_ready_i = 1'b0;
   logic        req_o;
   logic [31:0] req_addr_o;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_stall_cnt_o;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int gnt_pct     = 100;
   int rv_pct      = 100;

   // Reference model state
   logic [31:0] m_pc;
   bit          m_started;
   int          m_discard;
   ent_t        m_q[$];
   logic [31:0] m_stall;
   logic [31:0] bus_q[$];

   // Expected values for the current cycle
   logic        exp_req;
   logic [31:0] exp_addr;
   logic        exp_valid;
   logic [31:0] exp_inst;
   logic [31:0] exp_inst_addr;
   logic        dut_req;
   logic [31:0] dut_addr;

   pc_fetch_unit #(
      .ADDR_W    (32),
      .RESET_ADDR(RST_A),
      .DEPTH     (DEPTH),
      .INC       (INC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .jtag_reset_flag_i(jtag_reset_flag_i),
      .jump_flag_i      (jump_flag_i),
      .jump_addr_i      (jump_addr_i),
      .hold_i           (hold_i),
      .req_o            (req_o),
      .req_addr_o       (req_addr_o),
      .gnt_i            (gnt_i),
      .rvalid_i         (rvalid_i),
      .rdata_i          (rdata_i),
      .inst_valid_o     (inst_valid_o),
      .inst_o           (inst_o),
      .inst_addr_o      (inst_addr_o),
      .inst_ready_i     (inst_ready_i)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_stall_cnt_o(fetch_stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Memory contents seen by the bus: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      m_pc      = RST_A;
      m_started = 0;
      m_discard = 0;
      m_q.delete();
      bus_q.delete();
      m_stall   = '0;
   endtask

   function automatic void eval();
      exp_req   = m_started && ((m_q.size() + m_discard) < int'(DEPTH)) &&
                  !hold_i && !jump_flag_i && !jtag_reset_flag_i;
      exp_addr  = m_pc;
      exp_valid = (m_q.size() > 0) && m_q[0].have;
      exp_inst      = exp_valid ? m_q[0].data : '0;
      exp_inst_addr = exp_valid ? m_q[0].addr : '0;
   endfunction

   // Advance the reference model by one clock using this cycle's inputs.
   function automatic void model_step();
      bit grant;
      bit pop;
      int unret;
      grant = exp_req && gnt_i;
      pop   = exp_valid && inst_ready_i;
      if (inst_ready_i && !exp_valid && m_started && (m_stall != 32'hFFFF_FFFF))
         m_stall = m_stall + 1;
      if (jump_flag_i || jtag_reset_flag_i) begin
         unret = 0;
         foreach (m_q[i]) if (!m_q[i].have) unret++;
         m_discard = m_discard + unret - (rvalid_i ? 1 : 0);
         m_q.delete();
         m_pc = jtag_reset_flag_i ? RST_A : jump_addr_i;
      end else begin
         if (rvalid_i) begin
            if (m_discard > 0) m_discard--;
            else begin
               for (int i = 0; i < m_q.size(); i++) begin
                  if (!m_q[i].have) begin
                     m_q[i].data = rdata_i;
                     m_q[i].have = 1;
                     break;
                  end
               end
            end
         end
         if (pop) m_q.delete(0);
         if (grant) begin
            m_q.push_back('{addr: m_pc, data: 32'h0, have: 0});
            m_pc = m_pc + INC;
         end
      end
      m_started = 1;
   endfunction

   // Drive bus inputs at the falling edge and compute expectations.
   task automatic pre();
      int r;
      @(negedge clk);
      if (gnt_pct >= 100) gnt_i = 1'b1;
      else gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
      r = int'($urandom_range(0, 99));
      if (bus_q.size() > 0 && r < rv_pct) begin
         rvalid_i = 1'b1;
         rdata_i  = mem_word(bus_q[0]);
      end else begin
         rvalid_i = 1'b0;
         rdata_i  = $urandom;
      end
      #1;
      eval();
      dut_req  = req_o;
      dut_addr = req_addr_o;
   endtask

   // Clock edge: update model and bus bookkeeping, then step off the edge.
   task automatic post();
      @(posedge clk);
      if (rst) begin
         model_step();
         if (rvalid_i && bus_q.size() > 0) bus_q.delete(0);
         if (dut_req && gnt_i) bus_q.push_back(dut_addr);
      end
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      inst_ready_i = 1'b1;
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         pre();
         vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", req_o); end
         vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
         vectors++; if (req_addr_o !== RST_A) begin miscompares++; $display("FAIL reset_req_addr: got %h want %h", req_addr_o, RST_A); end
         vectors++; if (inst_o !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h want 0", inst_o); end
         vectors++; if (inst_addr_o !== 32'h0) begin miscompares++; $display("FAIL reset_inst_addr: got %h want 0", inst_addr_o); end
`ifdef FETCH_PERF_CNT_EN
         vectors++; if (fetch_stall_cnt_o !== 32'h0) begin miscompares++; $display("FAIL reset_stall_cnt: got %0d want 0", fetch_stall_cnt_o); end
`endif
         post();
      end
      rst = 1'b1;
      pre();
      vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL reset_release_req: got %b want 0", req_o); end
      post();
   endtask

   task automatic test_stream();
      int k = 0;
      int pops = 0;
      inst_ready_i = 1'b1; gnt_pct = 100; rv_pct = 100;
      for (int c = 0; c < 20; c++) begin
         pre();
         if (dut_req && gnt_i) begin
            vectors++;
            if (req_addr_o !== RST_A + 32'(INC * k)) begin miscompares++; $display("FAIL stream_req_addr: got %h want %h", req_addr_o, RST_A + 32'(INC * k)); end
            k++;
         end
         vectors++; if (inst_valid_o !== exp_valid) begin miscompares++; $display("FAIL stream_valid c%0d: got %b want %b", c, inst_valid_o, exp_valid); end
         if (exp_valid) begin
            vectors++; if (inst_addr_o !== exp_inst_addr) begin miscompares++; $display("FAIL stream_inst_addr: got %h want %h", inst_addr_o, exp_inst_addr); end
            vectors++; if (inst_o !== exp_inst) begin miscompares++; $display("FAIL stream_inst: got %h want %h", inst_o, exp_inst); end
         end
         if (c >= 10 && inst_valid_o && inst_ready_i) pops++;
         post();
      end
      vectors++; if (pops != 10) begin miscompares++; $display("FAIL stream_throughput: got %0d pops want 10", pops); end
   endtask

   task automatic test_full();
      int grants = 0;
      inst_ready_i = 1'b0;
      jump_flag_i = 1'b1; jump_addr_i = 32'h200;
      pre();
      vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL full_jump_req: got %b want 0", req_o); end
      post();
      jump_flag_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         pre();
         if (dut_req && gnt_i) grants++;
         vectors++; if (req_o !== exp_req) begin miscompares++; $display("FAIL full_req c%0d: got %b want %b", c, req_o, exp_req); end
         post();
      end
      vectors++; if (grants != 4) begin miscompares++; $display("FAIL full_grants: got %0d want 4", grants); end
      inst_ready_i = 1'b1;
      pre();
      vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL full_pop_req: got %b want 0", req_o); end
      vectors++; if (inst_addr_o !== 32'h200) begin miscompares++; $display("FAIL full_head: got %h want 200", inst_addr_o); end
      post();
      pre();
      vectors++; if (req_o !== 1'b1) begin miscompares++; $display("FAIL full_after_pop_req: got %b want 1", req_o); end
      post();
   endtask

   task automatic test_jump_drop();
      logic [31:0] popped[$];
      inst_ready_i = 1'b1;
      jump_flag_i = 1'b1; jump_addr_i = 32'h300;
      pre(); post();
      jump_flag_i = 1'b0; rv_pct = 0;
      for (int c = 0; c < 2; c++) begin
         pre();
         vectors++; if (req_o !== exp_req) begin miscompares++; $display("FAIL jdrop_req c%0d: got %b want %b", c, req_o, exp_req); end
         post();
      end
      jump_flag_i = 1'b1; jump_addr_i = 32'h100;
      pre(); post();
      jump_flag_i = 1'b0; rv_pct = 100;
      for (int c = 0; c < 15; c++) begin
         pre();
         if (inst_valid_o && inst_ready_i) popped.push_back(inst_addr_o);
         post();
      end
      vectors++;
      if (popped.size() < 2) begin
         miscompares++; $display("FAIL jdrop_count: got %0d pops want >=2", popped.size());
      end else begin
         if (popped[0] !== 32'h100 || popped[1] !== 32'h104) begin
            miscompares++; $display("FAIL jdrop_addrs: got %h,%h want 100,104", popped[0], popped[1]);
         end
      end
   endtask

   task automatic test_jump_coincident();
      inst_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin pre(); post(); end
      jump_flag_i = 1'b1; jump_addr_i = 32'h400;
      pre();
      vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL jco_req: got %b want 0", req_o); end
      post();
      jump_flag_i = 1'b0;
      pre();
      vectors++; if (req_addr_o !== 32'h400) begin miscompares++; $display("FAIL jco_req_addr: got %h want 400", req_addr_o); end
      vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL jco_valid_n1: got %b want 0", inst_valid_o); end
      post();
      pre();
      vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL jco_valid_n2: got %b want 0", inst_valid_o); end
      post();
      pre();
      vectors++; if (inst_valid_o !== 1'b1) begin miscompares++; $display("FAIL jco_valid_n3: got %b want 1", inst_valid_o); end
      vectors++; if (inst_addr_o !== 32'h400) begin miscompares++; $display("FAIL jco_inst_addr: got %h want 400", inst_addr_o); end
      vectors++; if (inst_o !== mem_word(32'h400)) begin miscompares++; $display("FAIL jco_inst: got %h want %h", inst_o, mem_word(32'h400)); end
      post();
   endtask

   task automatic test_hold();
      logic [31:0] held_pc;
      int pops = 0;
      inst_ready_i = 1'b0;
      for (int c = 0; c < 6; c++) begin pre(); post(); end
      hold_i = 1'b1; inst_ready_i = 1'b1;
      held_pc = m_pc;
      for (int c = 0; c < 5; c++) begin
         pre();
         vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL hold_req c%0d: got %b want 0", c, req_o); end
         if (inst_valid_o && inst_ready_i) pops++;
         post();
      end
      hold_i = 1'b0;
      pre();
      vectors++; if (pops != 4) begin miscompares++; $display("FAIL hold_pops: got %0d want 4", pops); end
      vectors++; if (req_o !== 1'b1) begin miscompares++; $display("FAIL hold_resume_req: got %b want 1", req_o); end
      vectors++; if (req_addr_o !== held_pc) begin miscompares++; $display("FAIL hold_resume_addr: got %h want %h", req_addr_o, held_pc); end
      post();
   endtask

   task automatic test_jtag();
      inst_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin pre(); post(); end
      jtag_reset_flag_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h800;
      pre();
      vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL jtag_req: got %b want 0", req_o); end
      post();
      jtag_reset_flag_i = 1'b0; jump_flag_i = 1'b0;
      pre();
      vectors++; if (req_addr_o !== RST_A) begin miscompares++; $display("FAIL jtag_req_addr: got %h want %h", req_addr_o, RST_A); end
      vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL jtag_valid: got %b want 0", inst_valid_o); end
      post();
   endtask

   task automatic test_midreset();
      #3 rst = 1'b0;
      jump_flag_i = 1'b0; jtag_reset_flag_i = 1'b0; hold_i = 1'b0;
      #1;
      vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL midrst_req: got %b want 0", req_o); end
      vectors++; if (inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", inst_valid_o); end
      vectors++; if (req_addr_o !== RST_A) begin miscompares++; $display("FAIL midrst_req_addr: got %h want %h", req_addr_o, RST_A); end
      vectors++; if (inst_addr_o !== 32'h0) begin miscompares++; $display("FAIL midrst_inst_addr: got %h want 0", inst_addr_o); end
`ifdef FETCH_PERF_CNT_EN
      vectors++; if (fetch_stall_cnt_o !== 32'h0) begin miscompares++; $display("FAIL midrst_stall_cnt: got %0d want 0", fetch_stall_cnt_o); end
`endif
      model_reset();
      pre(); post();
      rst = 1'b1;
      pre();
      vectors++; if (req_o !== 1'b0) begin miscompares++; $display("FAIL midrst_release_req: got %b want 0", req_o); end
      post();
   endtask

   task automatic test_random(input int cycles);
      logic [31:0] r;
      gnt_pct = 70; rv_pct = 60;
      for (int c = 0; c < cycles; c++) begin
         inst_ready_i      = ($urandom_range(0, 3) != 0);
         hold_i            = ($urandom_range(0, 9) == 0);
         jump_flag_i       = ($urandom_range(0, 24) == 0);
         jtag_reset_flag_i = ($urandom_range(0, 96) == 0);
         r = $urandom;
         jump_addr_i = r & 32'hFFFF_FFFC;
         pre();
         vectors++; if (req_o !== exp_req) begin miscompares++; $display("FAIL rand_req c%0d: got %b want %b", c, req_o, exp_req); end
         vectors++; if (req_addr_o !== exp_addr) begin miscompares++; $display("FAIL rand_req_addr c%0d: got %h want %h", c, req_addr_o, exp_addr); end
         vectors++; if (inst_valid_o !== exp_valid) begin miscompares++; $display("FAIL rand_valid c%0d: got %b want %b", c, inst_valid_o, exp_valid); end
         if (exp_valid) begin
            vectors++; if (inst_addr_o !== exp_inst_addr) begin miscompares++; $display("FAIL rand_inst_addr c%0d: got %h want %h", c, inst_addr_o, exp_inst_addr); end
            vectors++; if (inst_o !== exp_inst) begin miscompares++; $display("FAIL rand_inst c%0d: got %h want %h", c, inst_o, exp_inst); end
         end
`ifdef FETCH_PERF_CNT_EN
         vectors++; if (fetch_stall_cnt_o !== m_stall) begin miscompares++; $display("FAIL rand_stall_cnt c%0d: got %0d want %0d", c, fetch_stall_cnt_o, m_stall); end
`endif
         post();
      end
      jump_flag_i = 1'b0; jtag_reset_flag_i = 1'b0; hold_i = 1'b0;
      gnt_pct = 100; rv_pct = 100;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_jump_drop();
      test_jump_coincident();
      test_hold();
      test_jtag();
      test_random(800);
      test_midreset();
      test_random(800);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
